// File: rtl/inst_word_encoder.sv
// Sequential TSC 16-bit instruction encoder: descriptors in, packed words with addresses out.
// Define INST_ENC_CHECK_EN to enable the sticky illegal-descriptor flag on err.
module inst_word_encoder #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_type,
  input  logic [3:0]        req_sel,
  input  logic [1:0]        req_rs,
  input  logic [1:0]        req_rt,
  input  logic [1:0]        req_rd,
  input  logic [11:0]       req_imm,
  input  logic              req_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_word,
  output logic [ADDR_W-1:0] out_addr,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [15:0]       WORD_NOP = 16'hF03F;
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

  state_t              state_q, state_d;
  logic                out_valid_q, out_valid_d;
  logic [15:0]         out_word_q, out_word_d;
  logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
  logic                last_q, last_d;
  logic [15:0]         raw_word, enc_word;
  logic                enc_legal;
  logic                accept, emit;

  always_comb begin
    raw_word  = WORD_NOP;
    enc_legal = 1'b1;
    case (req_type)
      3'd0: begin
        // Unary ALU ops (NOT, TCP, SHL, SHR) carry no rt operand.
        if (req_sel < 4'd4)
          raw_word = {4'hF, req_rs, req_rt, req_rd, 3'b000, req_sel[2:0]};
        else if (req_sel < 4'd8)
          raw_word = {4'hF, req_rs, 2'b00, req_rd, 3'b000, req_sel[2:0]};
        else if (req_sel == 4'd8)
          raw_word = {4'h4, req_rs, req_rt, req_imm[7:0]};
        else if (req_sel == 4'd9)
          raw_word = {4'h5, req_rs, req_rt, req_imm[7:0]};
        else
          enc_legal = 1'b0;
      end
      3'd1: begin
        if (req_sel == 4'd0)
          raw_word = {4'h7, req_rs, req_rt, req_imm[7:0]};
        else if (req_sel == 4'd1)
          raw_word = {4'h6, 2'b00, req_rt, req_imm[7:0]};
        else
          enc_legal = 1'b0;
      end
      3'd2: begin
        if (req_sel == 4'd0)
          raw_word = {4'h8, req_rs, req_rt, req_imm[7:0]};
        else
          enc_legal = 1'b0;
      end
      3'd3: begin
        if (req_sel < 4'd4)
          raw_word = {2'b00, req_sel[1:0], req_rs, req_rt, req_imm[7:0]};
        else
          enc_legal = 1'b0;
      end
      3'd4: begin
        case (req_sel)
          4'd0:    raw_word = {4'h9, req_imm};
          4'd1:    raw_word = {4'hA, req_imm};
          4'd2:    raw_word = {4'hF, req_rs, 4'b0000, 6'd25};
          4'd3:    raw_word = {4'hF, req_rs, 4'b0000, 6'd26};
          default: enc_legal = 1'b0;
        endcase
      end
      3'd5: begin
        if (req_sel == 4'd0)
          raw_word = {4'hF, req_rs, 4'b0000, 6'd28};
        else
          enc_legal = 1'b0;
      end
      3'd6: begin
        if (req_sel == 4'd0)
          raw_word = WORD_NOP;
        else if (req_sel == 4'd1)
          raw_word = {4'hF, 6'b000000, 6'd29};
        else
          enc_legal = 1'b0;
      end
      default: enc_legal = 1'b0;
    endcase
    enc_word = enc_legal ? raw_word : WORD_NOP;
  end

  // Once the last descriptor is held in the output stage nothing more may enter.
  assign req_ready = (state_q == S_RUN) && !(out_valid_q && last_q) &&
                     (!out_valid_q || out_ready);
  assign accept    = req_valid && req_ready;
  assign emit      = out_valid_q && out_ready;

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_word_d  = out_word_q;
    out_addr_d  = out_addr_q;
    last_d      = last_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d    = S_RUN;
          out_addr_d = BASE;
          last_d     = 1'b0;
        end
      end
      S_RUN: begin
        if (emit && last_q) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
    if (emit) begin
      out_valid_d = 1'b0;
      out_addr_d  = out_addr_q + ADDR_W'(1);
    end
    if (accept) begin
      out_valid_d = 1'b1;
      out_word_d  = enc_word;
      last_d      = req_last;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      out_word_q  <= '0;
      out_addr_q  <= BASE;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_word_q  <= out_word_d;
      out_addr_q  <= out_addr_d;
      last_q      <= last_d;
    end
  end

`ifdef INST_ENC_CHECK_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (!reset_n)
      err_q <= 1'b0;
    else if (start && (state_q != S_RUN))
      err_q <= 1'b0;
    else if (accept && !enc_legal)
      err_q <= 1'b1;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign out_valid = out_valid_q;
  assign out_word  = out_word_q;
  assign out_addr  = out_addr_q;
  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_inst_word_encoder.sv
// Randomized self-checking bench for inst_word_encoder against a field-arithmetic reference model.
module tb_inst_word_encoder;

`ifdef INST_ENC_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif
  localparam int BUDGET = 2000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, req_valid, req_ready, req_last, out_valid, out_ready;
  logic [2:0]  req_type;
  logic [3:0]  req_sel;
  logic [1:0]  req_rs, req_rt, req_rd;
  logic [11:0] req_imm;
  logic [15:0] out_word;
  logic [15:0] out_addr;
  logic        busy, done, err;

  logic        b_start, b_req_valid, b_req_ready, b_req_last, b_out_valid, b_out_ready;
  logic [15:0] b_out_word;
  logic [3:0]  b_out_addr;
  logic        b_busy, b_done, b_err;

  always #5 clk = ~clk;

  inst_word_encoder dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type), .req_sel(req_sel),
    .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd), .req_imm(req_imm), .req_last(req_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word), .out_addr(out_addr),
    .busy(busy), .done(done), .err(err)
  );

  inst_word_encoder #(.ADDR_W(4), .BASE_ADDR(14)) dut4 (
    .clk(clk), .reset_n(reset_n), .start(b_start),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_type(3'd6), .req_sel(4'd0),
    .req_rs(2'd0), .req_rt(2'd0), .req_rd(2'd0), .req_imm(12'd0), .req_last(b_req_last),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_word(b_out_word), .out_addr(b_out_addr),
    .busy(b_busy), .done(b_done), .err(b_err)
  );

  typedef struct { int t; int s; int rs; int rt; int rd; int imm; bit last; } desc_t;
  typedef struct { int word; bit legal; int typ; } exp_t;

  desc_t prog[$];
  exp_t  expq[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  bit    m_err    = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic void ref_enc(input desc_t d, output int word, output bit legal);
    int i8;
    i8    = d.imm % 256;
    legal = 1'b1;
    word  = 'hF03F;
    case (d.t)
      0: if (d.s < 8)       word = 'hF000 + d.rs*1024 + ((d.s < 4) ? d.rt*256 : 0) + d.rd*64 + d.s;
         else if (d.s == 8) word = 4*4096 + d.rs*1024 + d.rt*256 + i8;
         else if (d.s == 9) word = 5*4096 + d.rs*1024 + d.rt*256 + i8;
         else               legal = 1'b0;
      1: if (d.s == 0)      word = 7*4096 + d.rs*1024 + d.rt*256 + i8;
         else if (d.s == 1) word = 6*4096 + d.rt*256 + i8;
         else               legal = 1'b0;
      2: if (d.s == 0)      word = 8*4096 + d.rs*1024 + d.rt*256 + i8;
         else               legal = 1'b0;
      3: if (d.s < 4)       word = d.s*4096 + d.rs*1024 + d.rt*256 + i8;
         else               legal = 1'b0;
      4: case (d.s)
           0: word = 9*4096 + d.imm;
           1: word = 10*4096 + d.imm;
           2: word = 'hF000 + d.rs*1024 + 25;
           3: word = 'hF000 + d.rs*1024 + 26;
           default: legal = 1'b0;
         endcase
      5: if (d.s == 0)      word = 'hF000 + d.rs*1024 + 28;
         else               legal = 1'b0;
      6: if (d.s == 0)      word = 'hF03F;
         else if (d.s == 1) word = 'hF000 + 29;
         else               legal = 1'b0;
      default: legal = 1'b0;
    endcase
    if (!legal) word = 'hF03F;
  endfunction

  // Instruction-type decoder used for the round-trip check.
  function automatic int dec_type(input int w);
    int op, fn;
    op = w / 4096;
    fn = w % 64;
    if (op <= 3) return 3;
    if (op == 4 || op == 5) return 0;
    if (op == 6 || op == 7) return 1;
    if (op == 8) return 2;
    if (op == 9 || op == 10) return 4;
    if (op == 15) begin
      if (fn <= 7) return 0;
      if (fn == 25 || fn == 26) return 4;
      if (fn == 28) return 5;
      if (fn == 29 || fn == 63) return 6;
    end
    return 7;
  endfunction

  task automatic add(input int t, input int s, input int rs, input int rt, input int rd,
                     input int imm, input bit last);
    desc_t d;
    d.t = t; d.s = s; d.rs = rs; d.rt = rt; d.rd = rd; d.imm = imm; d.last = last;
    prog.push_back(d);
  endtask

  // mode 0: full rate, 1: random valid/ready plus stray starts, 2: sink stalls for cycles 1..3
  task automatic run_prog(input int mode);
    int    idx = 0, cyc = 0, emitted = 0, m_state, w;
    bit    m_pend = 0, m_last_acc = 0, acc, emit, exp_ready, lg;
    exp_t  e;
    expq.delete();
    @(negedge clk);
    start = 1'b1; req_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    m_state = 1;
    m_err   = 1'b0;
    @(negedge clk);
    while (m_state == 1 && cyc < BUDGET) begin
      start     = (mode == 1) && ($urandom_range(99) < 5);
      req_valid = (idx < prog.size()) && (mode != 1 || $urandom_range(99) < 70);
      if (idx < prog.size()) begin
        req_type = 3'(prog[idx].t);  req_sel = 4'(prog[idx].s);
        req_rs   = 2'(prog[idx].rs); req_rt  = 2'(prog[idx].rt); req_rd = 2'(prog[idx].rd);
        req_imm  = 12'(prog[idx].imm); req_last = prog[idx].last;
      end
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(99) < 70);
        default: out_ready = !(cyc >= 1 && cyc <= 3);
      endcase
      #1;
      exp_ready = !m_last_acc && (!m_pend || out_ready);
      chk("req_ready", req_ready, exp_ready);
      chk("out_valid", out_valid, m_pend);
      chk("busy", busy, 1);
      chk("done", done, 0);
      chk("err", err, m_err);
      if (m_pend) begin
        chk("out_word", out_word, expq[0].word);
        chk("out_addr", out_addr, emitted % 65536);
      end
      acc  = req_valid && exp_ready;
      emit = m_pend && out_ready;
      if (emit && expq[0].legal) chk("roundtrip", dec_type(out_word), expq[0].typ);
      @(posedge clk);
      if (emit) begin
        e = expq.pop_front();
        emitted++;
        m_pend = 1'b0;
        if (m_last_acc && expq.size() == 0) m_state = 2;
      end
      if (acc) begin
        ref_enc(prog[idx], w, lg);
        e.word = w; e.legal = lg; e.typ = prog[idx].t;
        expq.push_back(e);
        m_pend = 1'b1;
        if (!lg && CHECK_EN) m_err = 1'b1;
        if (prog[idx].last) m_last_acc = 1'b1;
        idx++;
      end
      cyc++;
      @(negedge clk);
    end
    start = 1'b0; req_valid = 1'b0;
    chk("timeout", cyc < BUDGET, 1);
    #1;
    chk("done_end", done, 1);
    chk("req_ready_end", req_ready, 0);
    chk("busy_end", busy, 0);
    chk("out_valid_end", out_valid, 0);
    chk("err_end", err, m_err);
    chk("word_count", emitted, prog.size());
    prog.delete();
  endtask

  initial begin
    int exp4[3];
    int e4, k4;
    exp4 = '{14, 15, 0};
    reset_n = 1'b0; start = 1'b0; req_valid = 1'b0; out_ready = 1'b1;
    req_type = '0; req_sel = '0; req_rs = '0; req_rt = '0; req_rd = '0; req_imm = '0; req_last = 1'b0;
    b_start = 1'b0; b_req_valid = 1'b0; b_req_last = 1'b0; b_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_word", out_word, 0);
    chk("rst_out_addr", out_addr, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_addr_base14", b_out_addr, 14);
    reset_n = 1'b1;

    // Narrow-address instance: three NOPs wrap from 15 to 0.
    @(negedge clk); b_start = 1'b1;
    @(negedge clk); b_start = 1'b0;
    e4 = 0; k4 = 0;
    for (int c = 0; c < 50 && e4 < 3; c++) begin
      b_req_valid = (k4 < 3);
      b_req_last  = (k4 == 2);
      #1;
      if (b_out_valid && b_out_ready) begin
        chk("w4_addr", b_out_addr, exp4[e4]);
        chk("w4_word", b_out_word, 16'hF03F);
        e4++;
      end
      if (b_req_valid && b_req_ready) k4++;
      @(negedge clk);
    end
    b_req_valid = 1'b0;
    chk("w4_count", e4, 3);
    chk("w4_done", b_done, 1);

    add(0, 0, 1, 2, 3, 0, 1);                         // ADD -> F6C0 at 0
    run_prog(0);
    add(0, 8, 1, 1, 0, 'h05, 0); add(4, 1, 0, 0, 0, 'h123, 1);  // ADI, JAL
    run_prog(0);
    add(1, 0, 2, 3, 0, 'h7F, 0); add(2, 0, 1, 0, 0, 'h10, 0); add(3, 2, 3, 0, 0, 'hFE, 1);
    run_prog(2);
    add(7, 0, 1, 1, 1, 'hFFF, 0); add(0, 1, 3, 3, 3, 0, 1);      // illegal type 7
    run_prog(0);
    begin
      int nl[7];
      nl = '{10, 2, 1, 4, 4, 1, 2};
      for (int t = 0; t < 7; t++)
        for (int s = 0; s < nl[t]; s++)
          add(t, s, $urandom_range(3), $urandom_range(3), $urandom_range(3),
              $urandom_range(4095), (t == 6 && s == 1));
    end
    run_prog(1);                                       // start clears the earlier err
    for (int i = 0; i < 60; i++)
      add($urandom_range(7), ($urandom_range(3) == 0) ? $urandom_range(15) : $urandom_range(3),
          $urandom_range(3), $urandom_range(3), $urandom_range(3), $urandom_range(4095), i == 59);
    run_prog(1);

    // Reset while a word is pending.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; out_ready = 1'b0;
    req_valid = 1'b1; req_type = 3'd0; req_sel = 4'd0; req_last = 1'b0;
    @(negedge clk); req_valid = 1'b0;
    chk("mid_pending", out_valid, 1);
    reset_n = 1'b0;
    @(negedge clk);
    chk("mid_out_valid", out_valid, 0);
    chk("mid_busy", busy, 0);
    chk("mid_req_ready", req_ready, 0);
    chk("mid_out_addr", out_addr, 0);
    chk("mid_err", err, 0);
    reset_n = 1'b1; out_ready = 1'b1;
    add(5, 0, 2, 0, 0, 0, 0); add(6, 1, 0, 0, 0, 0, 1);         // WWD, HLT
    run_prog(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_word_encoder.md
# inst_word_encoder

Sequential instruction encoder for the TSC 16-bit ISA, the inverse of the instruction-type decoder. It accepts compact instruction descriptors (type, sub-op, register fields, immediate) over a valid/ready handshake and emits packed 16-bit instruction words with sequential memory addresses over a second valid/ready handshake. The program loader path uses it to fill instruction memory before the CPU is released from reset.

## Interface
- `ADDR_W`, default 16: output address width.
- `BASE_ADDR`, default 0: first address written after `start`.
- `clk` in 1: clock, rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `start` in 1: one-cycle pulse; begins a program load.
- `req_valid` in 1: descriptor valid.
- `req_ready` out 1: descriptor accepted when high with `req_valid`.
- `req_type` in 3: RTYPE=0, LOAD=1, STORE=2, BRANCH=3, JUMP=4, OUTPUT=5, NOP=6; 7 is illegal.
- `req_sel` in 4: sub-op within the type.
- `req_rs`, `req_rt`, `req_rd` in 2 each: register fields.
- `req_imm` in 12: [7:0] for I-type, [11:0] for J-type.
- `req_last` in 1: marks the final descriptor of the program.
- `out_valid` out 1: word valid.
- `out_ready` in 1: sink accepts the word.
- `out_word` out 16: encoded instruction.
- `out_addr` out ADDR_W: memory address for `out_word`.
- `busy` out 1: high in RUN.
- `done` out 1: high in DONE.
- `err` out 1: sticky illegal-descriptor flag.

## Operation
- Field layout:
  - R-format: op[15:12], rs[11:10], rt[9:8], rd[7:6], func[5:0].
  - I-format: op, rs, rt, imm[7:0].
  - J-format: op, target[11:0].
- Sub-op encoding per type:
  - RTYPE: sel 0–7 gives op 15, func 0–7 (ADD, SUB, AND, ORR, NOT, TCP, SHL, SHR). Sel 8 gives ADI (op 4); sel 9 gives ORI (op 5), both I-format.
  - LOAD: sel 0 gives LWD (op 7, I-format); sel 1 gives LHI (op 6, rs field = 0).
  - STORE: sel 0 gives SWD (op 8).
  - BRANCH: sel 0–3 gives BNE, BEQ, BGZ, BLZ (op 0–3, I-format).
  - JUMP: sel 0 gives JMP (op 9); sel 1 gives JAL (op 10), both J-format. Sel 2 gives JPR (op 15, func 25); sel 3 gives JRL (op 15, func 26).
  - OUTPUT: sel 0 gives WWD (op 15, func 28).
  - NOP: sel 0 gives NOP, word 0xF03F; sel 1 gives HLT (op 15, func 29).
  - Unused R-format fields are encoded as 0.
- Any other (type, sel) pair is illegal:
  - The emitted word is 0xF03F.
  - The address is still consumed.
- FSM:
  - IDLE: `req_ready`=0. `start` loads the address counter with BASE_ADDR, clears `err`, and moves to RUN.
  - RUN: accepts descriptors. The handshake of the output word carrying `req_last` moves to DONE.
  - DONE: `req_ready`=0, `done`=1. `start` behaves as in IDLE.
  - `start` while in RUN is ignored.
- The address counter increments on each output handshake and wraps modulo 2^ADDR_W.

## Timing
- Reset values: state IDLE, `out_valid`=0, `out_word`=0, `out_addr`=BASE_ADDR, `req_ready`=0, `busy`=0, `done`=0, `err`=0.
- Single registered output stage:
  - `req_ready` = RUN && (!`out_valid` || `out_ready`), i.e. one word per cycle at full throughput.
  - Latency is one cycle from descriptor handshake to `out_valid`.
- `out_word` and `out_addr` hold stable while `out_valid` && !`out_ready`.
- Accept and emit in the same cycle: the new word replaces the old one, and `out_addr` advances by 1.
- The `req_last` word's handshake sets `done` on the next cycle. No descriptor is accepted after `req_last` is accepted.
- Reset mid-load discards the pending word and returns to IDLE.

## Configuration
- `INST_ENC_CHECK_EN` defined:
  - An illegal descriptor sets `err` in the cycle after acceptance.
  - `err` stays high until the next `start` or reset.
- Not defined:
  - `err` is tied to 0.
  - Illegal descriptors are still silently encoded as 0xF03F.

## Test plan
- Reset, then `start`; feed ADD with rs=1, rt=2, rd=3 -> `out_word`=0xF6C0 at `out_addr`=0 one cycle later.
- Feed ADI (type 0, sel 8) with rs=1, rt=1, imm=0x05, then JAL (type 4, sel 1) with imm=0x123 and `req_last` -> 0x4505 at addr 0, 0xA123 at addr 1, then `done`=1 and `req_ready`=0.
- Hold `out_ready`=0 for 3 cycles with a word pending -> `out_word`/`out_addr` stable, `req_ready`=0; one descriptor accepted in the cycle `out_ready` rises.
- Set ADDR_W=4, BASE_ADDR=14 and feed 3 NOPs -> addresses 14, 15, 0, all words 0xF03F.
- Feed type 7 -> 0xF03F emitted; `err`=1 with `INST_ENC_CHECK_EN`, 0 without; the next `start` clears it.
- Round-trip: every legal (type, sel) pair is fed through the instruction-type decoder -> the decoded type equals `req_type`.
